ringosc_cnt_reader: RTL and testbench

Synchronous measurement controller for the ring-oscillator ripple counter. It drives the counter's stop, reset and shift controls to clear it and open a gate of a programmed number of `clk` cycles. It then freezes the oscillator and reads the 64-bit count back through the counter's 8-bit shifted window, one byte at a time, with double-sample glitch checking. It sits between the host logic (or a debug port) and the counter macro, and is the reading end of the counter's control and readout interface.

---
 rtl/ringosc_cnt_reader.sv | 214 +++++++++++++++++++++
 tb/tb_ringosc_cnt_reader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ringosc_cnt_reader.sv
// ringosc_cnt_reader: measurement controller for the ring-oscillator ripple
// counter. It clears the counter, opens a gate of a programmed number of clk
// cycles, freezes the oscillator, lets the ripple chain settle, then reads the
// 64-bit count back one byte at a time through the counter's 8-bit shifted
// window. Each byte is sampled twice and re-read on disagreement.
module ringosc_cnt_reader #(
    parameter int GATE_W        = 24,
    parameter int CLR_CYCLES    = 2,
    parameter int SETTLE_CYCLES = 4,
    parameter int SAMPLE_WAIT   = 2,
    parameter int MAX_RETRY     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [GATE_W-1:0] gate_cycles,
    input  logic [7:0]        cnt_byte,
    output logic [5:0]        cnt_shift,
    output logic              cnt_stop,
    output logic              cnt_reset,
    output logic              busy,
    output logic              done,
    output logic              result_valid,
    output logic [63:0]       result,
    output logic              err
);

    // The phase counter shares one register for CLEAR, GATE and SETTLE, so it
    // must be wide enough for the gate length and for the short fixed delays.
    localparam int CNT_W = (GATE_W > 8) ? GATE_W : 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_GATE,
        S_SETTLE,
        S_READ,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  gate_len_q, gate_len_d;
    logic [2:0]        byte_idx_q, byte_idx_d;
    logic [7:0]        phase_q, phase_d;
    logic [7:0]        retry_q, retry_d;
    logic [7:0]        samp_a_q, samp_a_d;
    logic [5:0]        cnt_shift_q, cnt_shift_d;
    logic              cnt_stop_q, cnt_stop_d;
    logic              cnt_reset_q, cnt_reset_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              result_valid_q, result_valid_d;
    logic [63:0]       result_q, result_d;
    logic              err_q, err_d;

    // Next-state and next-output computation; outputs are decoded from the
    // next state so every output is a flop.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        gate_len_d     = gate_len_q;
        byte_idx_d     = byte_idx_q;
        phase_d        = phase_q;
        retry_d        = retry_q;
        samp_a_d       = samp_a_q;
        result_d       = result_q;
        err_d          = err_q;
        result_valid_d = result_valid_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d        = S_CLEAR;
                    cnt_d          = '0;
                    // A zero gate length still opens the gate for one cycle.
                    gate_len_d     = (gate_cycles == '0) ? CNT_W'(1) : CNT_W'(gate_cycles);
                    result_valid_d = 1'b0;
                    err_d          = 1'b0;
                end
            end
            S_CLEAR: begin
                if (cnt_q == CNT_W'(CLR_CYCLES - 1)) begin
                    state_d = S_GATE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GATE: begin
                if (cnt_q == gate_len_q - 1'b1) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_d    = S_READ;
                    cnt_d      = '0;
                    byte_idx_d = 3'd0;
                    phase_d    = 8'd0;
                    retry_d    = 8'd0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_READ: begin
                if (phase_q == 8'(SAMPLE_WAIT)) begin
                    samp_a_d = cnt_byte;
                    phase_d  = phase_q + 8'd1;
                end else if (phase_q == 8'(SAMPLE_WAIT + 1)) begin
                    // cnt_byte here is sample B; accept it on agreement or when
                    // the retry budget for this byte is spent.
                    if ((samp_a_q == cnt_byte) || (retry_q == 8'(MAX_RETRY))) begin
                        result_d[{byte_idx_q, 3'b000} +: 8] = cnt_byte;
                        if (samp_a_q != cnt_byte) begin
                            err_d = 1'b1;
                        end
                        phase_d = 8'd0;
                        retry_d = 8'd0;
                        if (byte_idx_q == 3'd7) begin
                            state_d        = S_DONE;
                            result_valid_d = 1'b1;
                        end else begin
                            byte_idx_d = byte_idx_q + 3'd1;
                        end
                    end else begin
                        retry_d = retry_q + 8'd1;
                        phase_d = 8'd0;
                    end
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over everything, including a start seen in IDLE and a
        // byte completing on the same edge; status flags are left untouched.
        if (abort) begin
            state_d        = S_IDLE;
            result_valid_d = result_valid_q;
            err_d          = err_q;
            result_d       = result_q;
        end

        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        cnt_stop_d  = (state_d != S_GATE);
        cnt_reset_d = (state_d == S_CLEAR);
        if (state_d == S_READ) begin
            cnt_shift_d = {byte_idx_d, 3'b000};
        end else if (state_d == S_IDLE) begin
            cnt_shift_d = 6'd0;
        end else begin
            cnt_shift_d = cnt_shift_q;
        end
    end

    // State, datapath and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            gate_len_q     <= CNT_W'(1);
            byte_idx_q     <= 3'd0;
            phase_q        <= 8'd0;
            retry_q        <= 8'd0;
            samp_a_q       <= 8'd0;
            cnt_shift_q    <= 6'd0;
            cnt_stop_q     <= 1'b1;
            cnt_reset_q    <= 1'b1;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            result_valid_q <= 1'b0;
            result_q       <= 64'd0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            gate_len_q     <= gate_len_d;
            byte_idx_q     <= byte_idx_d;
            phase_q        <= phase_d;
            retry_q        <= retry_d;
            samp_a_q       <= samp_a_d;
            cnt_shift_q    <= cnt_shift_d;
            cnt_stop_q     <= cnt_stop_d;
            cnt_reset_q    <= cnt_reset_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            result_valid_q <= result_valid_d;
            result_q       <= result_d;
            err_q          <= err_d;
        end
    end

    assign cnt_shift    = cnt_shift_q;
    assign cnt_stop     = cnt_stop_q;
    assign cnt_reset    = cnt_reset_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign result_valid = result_valid_q;
    assign result       = result_q;
    assign err          = err_q;

endmodule

// File: tb/tb_ringosc_cnt_reader.sv
// Bench for ringosc_cnt_reader: a frozen-counter model drives the shifted
// window, and a cycle schedule derived from the measurement rules decides when
// sample B of a byte is corrupted and when done is due.
module tb_ringosc_cnt_reader;

    localparam int GATE_W = 24;
    localparam int CLR    = 2;
    localparam int SETTLE = 4;
    localparam int SW     = 2;
    localparam int MR     = 3;
    localparam int ATT    = SW + 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [GATE_W-1:0] gate_cycles;
    logic [7:0]        cnt_byte;
    logic [5:0]        cnt_shift;
    logic              cnt_stop;
    logic              cnt_reset;
    logic              busy;
    logic              done;
    logic              result_valid;
    logic [63:0]       result;
    logic              err;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] cval;
    logic [63:0] win;
    logic [511:0] flip_mask;
    int          cyc;
    int          flips[8];

    always #5 clk = ~clk;

    ringosc_cnt_reader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .gate_cycles  (gate_cycles),
        .cnt_byte     (cnt_byte),
        .cnt_shift    (cnt_shift),
        .cnt_stop     (cnt_stop),
        .cnt_reset    (cnt_reset),
        .busy         (busy),
        .done         (done),
        .result_valid (result_valid),
        .result       (result),
        .err          (err)
    );

    // Counter model: frozen count seen through the shift window, with bit 0
    // flipped in the scheduled glitch cycles.
    always_comb begin
        win      = cval >> cnt_shift;
        cnt_byte = win[7:0];
        if (cyc >= 0 && cyc < 512 && flip_mask[cyc[8:0]]) begin
            cnt_byte = cnt_byte ^ 8'h01;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One full measurement of frozen value v with gate g; flips[k] is the
    // number of leading attempts of byte k whose sample B is corrupted.
    task automatic run_meas(input logic [63:0] v, input int g, input int start_at);
        int gl, r, a, natt, exp_n, c, done_at, stop_low, rst_hi, shift_chg, stop_viol;
        logic [63:0] exp_res;
        logic        exp_err;
        logic [5:0]  prev_shift;
        gl = (g == 0) ? 1 : g;
        r  = CLR + gl + SETTLE;
        a  = 0;
        flip_mask = '0;
        exp_res   = 64'd0;
        exp_err   = 1'b0;
        for (int k = 0; k < 8; k++) begin
            natt = (flips[k] > MR) ? MR + 1 : flips[k] + 1;
            for (int j = 0; j < natt; j++) begin
                if (j < flips[k]) flip_mask[r + ATT * a + SW + 1] = 1'b1;
                a++;
            end
            exp_res[8*k +: 8] = v[8*k +: 8] ^ ((flips[k] > MR) ? 8'h01 : 8'h00);
            if (flips[k] > MR) exp_err = 1'b1;
        end
        exp_n = r + ATT * a;

        cval        = v;
        gate_cycles = GATE_W'(g);
        cyc         = -1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        c = 0;
        cyc = 0;
        done_at = -1;
        stop_low = 0;
        rst_hi = 0;
        shift_chg = 0;
        stop_viol = 0;
        prev_shift = cnt_shift;
        check_eq("accept_flags", {61'd0, busy, result_valid, err}, 64'h4);
        while (done_at < 0 && c <= exp_n + 20) begin
            if (cnt_shift != prev_shift) begin
                shift_chg++;
                if (cnt_stop !== 1'b1) stop_viol++;
                prev_shift = cnt_shift;
            end
            if (cnt_stop === 1'b0) stop_low++;
            if (cnt_reset === 1'b1) rst_hi++;
            if (done === 1'b1) begin
                done_at = c;
            end else begin
                start = (c == start_at);
                @(posedge clk);
                #1;
                start = 1'b0;
                c++;
                cyc = c;
            end
        end
        check_eq("done_cycle", 64'(done_at), 64'(exp_n));
        check_eq("result", result, exp_res);
        check_eq("err", {63'd0, err}, {63'd0, exp_err});
        check_eq("valid_at_done", {62'd0, result_valid, busy}, 64'h3);
        check_eq("gate_len", 64'(stop_low), 64'(gl));
        check_eq("clear_len", 64'(rst_hi), 64'(CLR));
        check_eq("shift_steps", 64'(shift_chg), 64'd7);
        check_eq("shift_while_running", 64'(stop_viol), 64'd0);
        check_eq("last_shift", {58'd0, cnt_shift}, 64'd56);
        @(posedge clk);
        #1;
        cyc = -1;
        check_eq("after_done", {61'd0, busy, done, result_valid}, 64'h1);
        check_eq("result_hold", result, exp_res);
    endtask

    initial begin
        int dcount;
        rst_n       = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        gate_cycles = '0;
        cval        = 64'd0;
        flip_mask   = '0;
        cyc         = -1;
        for (int k = 0; k < 8; k++) flips[k] = 0;

        // Reset values while held in reset, then idle after release.
        #2;
        rst_n = 1'b0;
        #2;
        check_eq("reset_ctl", {55'd0, cnt_stop, cnt_reset, cnt_shift, busy, done, result_valid, err},
                 {55'd0, 1'b1, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        check_eq("reset_result", result, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("idle_ctl", {61'd0, cnt_stop, cnt_reset, busy}, 64'h4);

        // Basic read, zero gate, single glitch, persistent glitch.
        run_meas(64'h0123_4567_89AB_CDEF, 10, -1);
        run_meas(64'hFEDC_BA98_7654_3210, 0, -1);
        flips[3] = 1;
        run_meas(64'h0123_4567_89AB_CDEF, 10, -1);
        flips[3] = 0;
        flips[5] = 4;
        run_meas(64'h0123_4567_89AB_CDEF, 10, -1);
        flips[5] = 0;

        // Start pulse during READ is ignored; err from the previous run clears.
        run_meas(64'hA5A5_5A5A_0F0F_F0F0, 10, 30);

        // Abort during GATE.
        cval        = 64'h1111_2222_3333_4444;
        flip_mask   = '0;
        gate_cycles = GATE_W'(10);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check_eq("abort_idle", {60'd0, busy, result_valid, cnt_stop, cnt_reset}, 64'h2);
        dcount = 0;
        for (int i = 0; i < 60; i++) begin
            if (done === 1'b1 || busy === 1'b1) dcount++;
            @(posedge clk);
            #1;
        end
        check_eq("abort_no_done", 64'(dcount), 64'd0);

        // Randomized measurements.
        for (int n = 0; n < 20; n++) begin
            for (int k = 0; k < 8; k++) begin
                flips[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
            end
            run_meas({$urandom(), $urandom()}, int'($urandom_range(0, 30)), -1);
        end
        for (int k = 0; k < 8; k++) flips[k] = 0;

        // Asynchronous reset in the middle of a measurement.
        cval        = 64'hDEAD_BEEF_CAFE_F00D;
        gate_cycles = GATE_W'(5);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_reset_ctl", {55'd0, cnt_stop, cnt_reset, cnt_shift, busy, done, result_valid, err},
                 {55'd0, 1'b1, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        check_eq("async_reset_result", result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
